// File: rtl/spmv_pkg.sv
// Shared types and helpers for the SpMV kernel row-accumulation stage.
package spmv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WALK  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int acc_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/spmv_lane_picker.sv
// Lowest-set-bit encoder: selects the next active lane of the current beat.
module spmv_lane_picker #(
    parameter int PARALLELISM = 4,
    localparam int IDX_W = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1
) (
    input  logic [PARALLELISM-1:0] mask,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = PARALLELISM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmv_row_accumulator.sv
// Sums consecutive same-row products and writes every row 0..LENGTH-1 once,
// in ascending order, zero-filling rows that received no products.
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int LENGTH      = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH),
    localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PARALLELISM-1:0][ACC_WIDTH-1:0]  in_data,
    input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] in_row,
    input  logic [PARALLELISM-1:0]                in_mask,
    input  logic                                  in_last,
    output logic                                  wr_valid,
    input  logic                                  wr_ready,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [ACC_WIDTH-1:0]                  wr_data
);

    localparam int IDX_W = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ADDR_WIDTH:0]   ROW_END  = (ADDR_WIDTH + 1)'(LENGTH);
    localparam logic [ADDR_WIDTH:0]   ROW_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t state, state_nxt;

    logic [PARALLELISM-1:0][ACC_WIDTH-1:0]  beat_data;
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] beat_row;
    logic [PARALLELISM-1:0]                remaining;
    logic                                  last_r;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [ADDR_WIDTH-1:0]       acc_row;
    logic                        acc_valid;
    logic [ADDR_WIDTH:0]         wr_row;
    logic                        error_r;
    logic                        done_r;

    logic [IDX_W-1:0]            lane_idx;
    logic                        lane_any;
    logic [PARALLELISM-1:0]      lane_bit;
    logic [ADDR_WIDTH-1:0]       lane_row;
    logic signed [ACC_WIDTH-1:0] lane_data;
    logic                        lane_below;

    logic consume, set_err, do_add, do_load, wr_fire, flush_done;

    spmv_lane_picker #(.PARALLELISM(PARALLELISM)) u_lane_picker (
        .mask (remaining),
        .idx  (lane_idx),
        .any  (lane_any)
    );

    assign lane_bit  = PARALLELISM'(1) << lane_idx;
    assign lane_row  = beat_row[lane_idx];
    assign lane_data = beat_data[lane_idx];
    // A lane behind the last accepted row can never be written in order.
    assign lane_below = ({1'b0, lane_row} < wr_row) || (acc_valid && (lane_row < acc_row));

    assign busy     = (state != IDLE);
    assign in_ready = (state == FETCH);
    assign done     = done_r;
    assign error    = error_r;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_nxt  = state;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        consume    = 1'b0;
        set_err    = 1'b0;
        do_add     = 1'b0;
        do_load    = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = FETCH;
            end
            FETCH: begin
                if (in_valid) state_nxt = WALK;
            end
            WALK: begin
                if (!lane_any) begin
                    state_nxt = last_r ? FLUSH : FETCH;
                end else if (lane_below) begin
                    set_err = 1'b1;
                    consume = 1'b1;
                end else if (acc_valid && (lane_row == acc_row)) begin
                    do_add  = 1'b1;
                    consume = 1'b1;
                end else if (acc_valid) begin
                    wr_valid = 1'b1;
                    wr_addr  = acc_row;
                    wr_data  = acc;
                end else if (wr_row < {1'b0, lane_row}) begin
                    wr_valid = 1'b1;
                    wr_addr  = wr_row[ADDR_WIDTH-1:0];
                end else begin
                    do_load = 1'b1;
                    consume = 1'b1;
                end
            end
            FLUSH: begin
                if (acc_valid) begin
                    wr_valid = 1'b1;
                    wr_addr  = acc_row;
                    wr_data  = acc;
                end else if (wr_row < ROW_END) begin
                    wr_valid = 1'b1;
                    wr_addr  = wr_row[ADDR_WIDTH-1:0];
                end
                flush_done = (wr_fire && (wr_addr == LAST_ROW)) || !wr_valid;
                if (flush_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            acc_valid <= 1'b0;
            acc       <= '0;
            acc_row   <= '0;
            wr_row    <= '0;
            beat_data <= '0;
            beat_row  <= '0;
            remaining <= '0;
            last_r    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= flush_done;
            if ((state == IDLE) && en) begin
                wr_row    <= '0;
                acc_valid <= 1'b0;
                error_r   <= 1'b0;
            end
            if ((state == FETCH) && in_valid) begin
                beat_data <= in_data;
                beat_row  <= in_row;
                remaining <= in_mask;
                last_r    <= in_last;
            end
            if (consume) remaining <= remaining & ~lane_bit;
            if (set_err) error_r <= 1'b1;
            if (do_add)  acc <= acc + lane_data;
            if (do_load) begin
                acc       <= lane_data;
                acc_row   <= lane_row;
                acc_valid <= 1'b1;
            end
            if (wr_fire) begin
                wr_row    <= wr_row + ROW_ONE;
                acc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Randomised and directed bench for spmv_row_accumulator against a row-sum model.
module tb_spmv_row_accumulator;

    localparam int LEN = 8;
    localparam int DW  = 32;
    localparam int P   = 4;
    localparam int AW  = 64;
    localparam int RW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic wr_ready = 1'b1;
    logic busy, done, error, in_ready, wr_valid;
    logic [P-1:0][AW-1:0] in_data = '0;
    logic [P-1:0][RW-1:0] in_row = '0;
    logic [P-1:0]         in_mask = '0;
    logic [RW-1:0]        wr_addr;
    logic [AW-1:0]        wr_data;

    spmv_row_accumulator #(
        .LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .busy(busy), .done(done), .error(error),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_row(in_row),
        .in_mask(in_mask), .in_last(in_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [RW-1:0] wq_addr[$];
    logic [AW-1:0] wq_data[$];
    int last_wr_cyc = 0;
    int stall_viol = 0;
    int ready_viol = 0;
    bit prev_stall = 0;
    logic [RW-1:0] prev_a;
    logic [AW-1:0] prev_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!wr_valid || wr_addr !== prev_a || wr_data !== prev_d)) stall_viol++;
            if (in_ready && (wr_valid || !busy)) ready_viol++;
            if (wr_valid && wr_ready) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                last_wr_cyc = cyc;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_a = wr_addr;
            prev_d = wr_data;
        end
    end

    int nb = 0;
    logic [RW-1:0] b_row [16][P];
    logic [AW-1:0] b_data[16][P];
    logic [P-1:0]  b_mask[16];
    logic [AW-1:0] exp_sum[LEN];
    bit exp_err;

    task automatic add_beat(input int r0, r1, r2, r3,
                            input logic [AW-1:0] d0, d1, d2, d3, input logic [P-1:0] m);
        b_row[nb][0] = RW'(r0); b_row[nb][1] = RW'(r1);
        b_row[nb][2] = RW'(r2); b_row[nb][3] = RW'(r3);
        b_data[nb][0] = d0; b_data[nb][1] = d1; b_data[nb][2] = d2; b_data[nb][3] = d3;
        b_mask[nb] = m;
        nb++;
    endtask

    // Row sums in stream order; a lane whose row is below the last kept row is dropped.
    function automatic void model();
        int cur = 0;
        exp_err = 0;
        for (int i = 0; i < LEN; i++) exp_sum[i] = '0;
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < P; l++)
                if (b_mask[b][l]) begin
                    if (int'(b_row[b][l]) < cur) exp_err = 1;
                    else begin
                        exp_sum[b_row[b][l]] = exp_sum[b_row[b][l]] + b_data[b][l];
                        cur = int'(b_row[b][l]);
                    end
                end
    endfunction

    task automatic start_run();
        wq_addr.delete();
        wq_data.delete();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic send_beat(input int b, output bit ok);
        in_valid = 1'b1;
        in_mask = b_mask[b];
        in_last = (b == nb - 1);
        for (int l = 0; l < P; l++) begin
            in_row[l] = b_row[b][l];
            in_data[l] = b_data[b][l];
        end
        ok = 0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            $display("FAIL beat_accept beat %0d: in_ready never seen, required within 2000 cycles", b);
            errors++;
        end
    endtask

    task automatic run_and_check(input string name, input bit do_start);
        bit ok;
        bit got = 0;
        int done_cyc = 0;
        model();
        if (do_start) start_run();
        for (int b = 0; b < nb; b++) begin
            send_beat(b, ok);
            if (!ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        // Keep offering junk after the last beat; it must never be taken.
        for (int l = 0; l < P; l++) begin
            in_data[l] = {$urandom, $urandom};
            in_row[l] = RW'($urandom);
        end
        in_mask = '1;
        for (int t = 0; t < 4000 && !got; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                done_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!got) begin
            $display("FAIL %s done_timeout: done=0 after 4000 cycles, required 1", name);
            errors++;
        end else begin
            checks++;
            if (done_cyc !== last_wr_cyc + 1) begin
                $display("FAIL %s done_timing: done at cycle %0d, required %0d", name, done_cyc, last_wr_cyc + 1);
                errors++;
            end
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s idle_after: done=%0b busy=%0b, required 0 0", name, done, busy);
            errors++;
        end
        checks++;
        if (wq_addr.size() != LEN) begin
            $display("FAIL %s write_count: got %0d, required %0d", name, wq_addr.size(), LEN);
            errors++;
        end
        for (int i = 0; i < wq_addr.size() && i < LEN; i++) begin
            checks++;
            if (wq_addr[i] !== RW'(i) || wq_data[i] !== exp_sum[i]) begin
                $display("FAIL %s write%0d: got (%0d,%h), required (%0d,%h)",
                         name, i, wq_addr[i], wq_data[i], i, exp_sum[i]);
                errors++;
            end
        end
        checks++;
        if (error !== exp_err) begin
            $display("FAIL %s error_flag: got %0b, required %0b", name, error, exp_err);
            errors++;
        end
        checks++;
        if (stall_viol != 0 || ready_viol != 0) begin
            $display("FAIL %s protocol: stall_changes=%0d ready_overlaps=%0d, required 0 0",
                     name, stall_viol, ready_viol);
            errors++;
        end
        stall_viol = 0;
        ready_viol = 0;
    endtask

    task automatic load_basic();
        nb = 0;
        add_beat(0, 0, 1, 3, 1, 2, 3, 4, 4'b1111);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, in_ready, wr_valid} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            $display("FAIL reset_outputs: busy/done/error/in_ready/wr_valid=%b addr=%0d data=%h, required all 0",
                     {busy, done, error, in_ready, wr_valid}, wr_addr, wr_data);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        ready_mode = 0;
        load_basic();
        run_and_check("basic", 1);
    endtask

    task automatic test_span();
        ready_mode = 0;
        nb = 0;
        add_beat(2, 2, 2, 2, 5, 5, 5, 5, 4'b1111);
        add_beat(2, 5, 5, 5, 5, 1, 1, 1, 4'b0111);
        run_and_check("span", 1);
    endtask

    task automatic test_back_to_back();
        ready_mode = 1;
        load_basic();
        run_and_check("backpressure", 1);
        ready_mode = 0;
    endtask

    task automatic test_error();
        ready_mode = 0;
        nb = 0;
        add_beat(3, 1, 4, 4, 1, 1, 1, 1, 4'b1111);
        run_and_check("decreasing", 1);
        start_run();
        checks++;
        if (error !== 1'b0) begin
            $display("FAIL error_clear: error=%0b after en, required 0", error);
            errors++;
        end
        nb = 0;
        add_beat(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        run_and_check("after_error", 0);
    endtask

    task automatic test_wrap();
        ready_mode = 0;
        nb = 0;
        add_beat(0, 0, 5, 6, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 7, 7, 4'b0011);
        run_and_check("wrap", 1);
        checks++;
        if (wq_data.size() == 0 || wq_data[0] !== 64'd0) begin
            $display("FAIL wrap_row0: got %h, required 0", (wq_data.size() == 0) ? 64'hx : wq_data[0]);
            errors++;
        end
        nb = 0;
        add_beat(1, 2, 3, 4, 9, 9, 9, 9, 4'b0000);
        run_and_check("empty_last", 1);
    endtask

    task automatic test_async_reset();
        bit ok;
        ready_mode = 0;
        nb = 0;
        add_beat(0, 1, 2, 3, 9, 9, 9, 9, 4'b1111);
        start_run();
        send_beat(0, ok);
        @(posedge clk); #2;
        checks++;
        if (wr_valid !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL async_pre: wr_valid=%0b busy=%0b, required 1 1", wr_valid, busy);
            errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || wr_valid !== 1'b0) begin
            $display("FAIL async_drop: busy=%0b in_ready=%0b wr_valid=%0b, required 0 0 0",
                     busy, in_ready, wr_valid);
            errors++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stall_viol = 0;
        ready_viol = 0;
        load_basic();
        run_and_check("after_reset", 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int cur;
            ready_mode = $urandom_range(0, 2);
            nb = $urandom_range(1, 4);
            cur = 0;
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < P; l++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        b_row[b][l] = RW'($urandom_range(0, LEN - 1));
                    end else begin
                        cur = cur + $urandom_range(0, 2);
                        if (cur > LEN - 1) cur = LEN - 1;
                        b_row[b][l] = RW'(cur);
                    end
                    b_data[b][l] = {$urandom, $urandom};
                end
                b_mask[b] = P'($urandom);
            end
            run_and_check($sformatf("random%0d", r), 1);
        end
        ready_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_span();
        test_back_to_back();
        test_error();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
